// File: rtl/boruss_rom_arbiter.sv
// boruss_rom_arbiter: shares the single combinational program-ROM read port
// between CPU instruction fetch (port F) and a debug/dump reader (port D).
// F has priority; after STARVE_LIMIT consecutive F grants with D pending,
// D is forced through. One access every three cycles (IDLE -> READ -> RESP).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   fetch_req/fetch_addr  F request, held until fetch_ack
//   fetch_ack/fetch_data  F one-cycle ack pulse, data held until next F ack
//   dbg_req/dbg_addr      D request, held until dbg_ack
//   dbg_ack/dbg_data      D one-cycle ack pulse, data held until next D ack
//   rom_addr/rom_data     registered ROM address, combinational ROM data
//   busy                  high while in READ or RESP
module boruss_rom_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t           state;
  logic             owner_dbg;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_dbg;

  // D wins when it is alone, or when F has starved it for STARVE_LIMIT grants
  assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_dbg = dbg_req && (!fetch_req || starved);

  // Access sequencer; requests are only sampled in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_dbg  <= 1'b0;
      starve_cnt <= '0;
      rom_addr   <= '0;
      fetch_data <= '0;
      dbg_data   <= '0;
      fetch_ack  <= 1'b0;
      dbg_ack    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      dbg_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || dbg_req) begin
            owner_dbg <= grant_dbg;
            rom_addr  <= grant_dbg ? dbg_addr : fetch_addr;
            busy      <= 1'b1;
            state     <= READ;
            // Count only F grants that made a pending D wait
            if (grant_dbg || !dbg_req) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        READ: begin
          if (owner_dbg) begin
            dbg_data <= rom_data;
          end else begin
            fetch_data <= rom_data;
          end
          fetch_ack <= !owner_dbg;
          dbg_ack   <= owner_dbg;
          state     <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_rom_arbiter.sv
// Testbench for boruss_rom_arbiter: directed stimulus pushes expected acks
// (port, data, cycle) into a scoreboard; a negedge monitor pops and compares.
module tb_boruss_rom_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = '0;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       dbg_req = 1'b0;
  logic [7:0] dbg_addr = '0;
  logic       dbg_ack;
  logic [7:0] dbg_data;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_dbg;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  boruss_rom_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy)
  );

  // ROM contents: 1 << min(addr/3, 7)
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    int q;
    q = int'(a) / 3;
    if (q > 7) q = 7;
    return 8'(1 << q);
  endfunction

  assign rom_data = rom_fn(rom_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (fetch_ack && dbg_ack) begin
      n_checks++;
      $display("FAIL both_acks: fetch_ack=1 dbg_ack=1 expected at most one (cycle %0d)", cyc);
    end else if (fetch_ack || dbg_ack) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: dbg=%0b at cycle %0d with empty scoreboard", dbg_ack, cyc);
      end else begin
        exp_t e;
        logic [7:0] d;
        e = sb.pop_front();
        d = dbg_ack ? dbg_data : fetch_data;
        if (dbg_ack == e.is_dbg && d === e.data && cyc == e.cyc) n_pass++;
        else $display("FAIL ack: got port_d=%0b data=0x%0h cycle=%0d expected port_d=%0b data=0x%0h cycle=%0d",
                      dbg_ack, d, cyc, e.is_dbg, e.data, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit d, input logic [7:0] addr, input int at);
    exp_t e;
    e.is_dbg = d;
    e.data   = rom_fn(addr);
    e.cyc    = at;
    sb.push_back(e);
  endtask

  // Single read from DUT IDLE; returns in the cycle after the ack
  task automatic do_read(input bit d, input logic [7:0] addr);
    if (d) begin dbg_req = 1'b1; dbg_addr = addr; end
    else begin fetch_req = 1'b1; fetch_addr = addr; end
    push(d, addr, cyc + 2);
    tick();
    check("busy_in_read", 32'(busy), 32'd1);
    repeat (2) tick();
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
  endtask

  initial begin
    // 1: reset
    repeat (2) tick();
    check("rst_fetch_ack", 32'(fetch_ack), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'h00);
    check("rst_fetch_data", 32'(fetch_data), 32'h00);
    check("rst_dbg_data", 32'(dbg_data), 32'h00);
    reset = 1'b0;

    // 2: single F read
    do_read(1'b0, 8'h18);
    check("f_read_dbg_data_kept", 32'(dbg_data), 32'h00);

    // 3: single D reads
    do_read(1'b1, 8'h15);
    do_read(1'b1, 8'h03);
    check("d_read_fetch_data_kept", 32'(fetch_data), 32'h80);
    check("idle_rom_addr_held", 32'(rom_addr), 32'h03);

    // 5: back-to-back F reads, acks every 3 cycles
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    push(1'b0, 8'h00, cyc + 2);
    repeat (3) tick();
    fetch_addr = 8'h03;
    push(1'b0, 8'h03, cyc + 2);
    repeat (3) tick();
    fetch_addr = 8'h06;
    push(1'b0, 8'h06, cyc + 2);
    repeat (3) tick();
    fetch_req = 1'b0;
    check("b2b_dbg_data_kept", 32'(dbg_data), 32'h02);

    // 4: contention from reset release, grant order F,F,F,F,D repeated
    reset = 1'b1;
    repeat (2) tick();
    reset      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'h06;
    dbg_req    = 1'b1;
    dbg_addr   = 8'h15;
    for (int i = 0; i < 10; i++) begin
      bit d;
      d = (i % 5) == 4;
      push(d, d ? 8'h15 : 8'h06, cyc + 2 + 3 * i);
    end
    repeat (30) tick();
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
    repeat (3) tick();

    // 6: reset during READ aborts the access
    fetch_req  = 1'b1;
    fetch_addr = 8'h0C;
    tick();
    reset     = 1'b1;
    fetch_req = 1'b0;
    tick();
    check("abort_fetch_ack", 32'(fetch_ack), 32'd0);
    check("abort_fetch_data", 32'(fetch_data), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'h00);
    tick();
    check("abort_no_late_ack", 32'(fetch_ack), 32'd0);
    reset = 1'b0;
    do_read(1'b0, 8'h0C);
    check("after_abort_fetch_data", 32'(fetch_data), 32'h10);

    repeat (5) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
